// File: rtl/lzc_pkg.sv
// lzc_pkg: shared types and helpers for the sequential leading-zero counter.
//   lzc_state_t : controller FSM states
//   cw_f(n)     : width needed to hold a count in the range 0..n
package lzc_pkg;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} lzc_state_t;

   function automatic int cw_f(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/lzc_seq_if.sv
// lzc_seq_if: request/result handshake bundle for lzc_seq.
//   in_valid/in_ready/in_data      : word to count (master -> slave)
//   out_valid/out_ready/out_count/out_zero : result (slave -> master)
// The master modport is the producer/consumer side; the slave modport is the counter.
interface lzc_seq_if
   import lzc_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int CW   = cw_f(WIDTH)
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [CW-1:0]    out_count;
   logic             out_zero;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_count, out_zero
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_count, out_zero
   );

endinterface

// File: rtl/lzc_chunk.sv
// lzc_chunk: combinational CHUNK-bit leading-zero counter.
//   d : chunk, MSB first
//   c : leading zeros, 0..CHUNK (all-zero chunk gives CHUNK)
// Built as a tree: 2-bit enc cells at the leaves, then log2(CHUNK)-1 merge levels.
// Every node carries a count whose MSB alone set means "this span is all zero".

// lzc_enc: 2-bit leaf. y = 2 (all zero), 1 (01), 0 (1x).
module lzc_enc (
   input  logic [1:0] b,
   output logic [1:0] y
);
   assign y = {~(b[1] | b[0]), ~b[1] & b[0]};
endmodule

// lzc_merge: joins the counts of an upper half a and lower half b, each W bits.
module lzc_merge #(
   parameter int W = 2
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W:0]   y
);
   always_comb begin
      if (a[W-1] & b[W-1])  y = {1'b1, {W{1'b0}}};
      else if (a[W-1])      y = {2'b01, b[W-2:0]};
      else                  y = {1'b0, a};
   end
endmodule

module lzc_chunk
   import lzc_pkg::*;
#(
   parameter int  CHUNK = 8,
   localparam int L     = $clog2(CHUNK),
   localparam int CCW   = cw_f(CHUNK)
) (
   input  logic [CHUNK-1:0] d,
   output logic [CCW-1:0]   c
);

   genvar lv, i;
   generate
      for (lv = 0; lv < L; lv++) begin : lvl
         localparam int N = CHUNK >> (lv + 1);
         logic [N-1:0][lv+1:0] n;
         for (i = 0; i < N; i++) begin : nd
            if (lv == 0) begin : g_enc
               lzc_enc u_enc (.b(d[2*i+1 -: 2]), .y(n[i]));
            end else begin : g_mrg
               // node 2i+1 covers the more significant bits
               lzc_merge #(.W(lv + 1)) u_mrg (
                  .a(lvl[lv-1].n[2*i+1]),
                  .b(lvl[lv-1].n[2*i]),
                  .y(n[i])
               );
            end
         end
      end
   endgenerate

   assign c = lvl[L-1].n[0];

endmodule

// File: rtl/lzc_seq.sv
// lzc_seq: multi-cycle leading-zero counter. Accepts a WIDTH-bit word, scans it
// MSB-first CHUNK bits per cycle through one shared lzc_chunk, stops at the first
// non-zero chunk and returns the count.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : lzc_seq_if slave (input word handshake, result handshake)
module lzc_seq
   import lzc_pkg::*;
#(
   parameter int  WIDTH = 32,
   parameter int  CHUNK = 8,
   localparam int CW    = cw_f(WIDTH)
) (
   input  logic       clk,
   input  logic       reset,
   lzc_seq_if.slave   bus
);

   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int CCW = cw_f(CHUNK);

   lzc_state_t       state, nxt;
   logic [WIDTH-1:0] sh;
   logic [CW-1:0]    acc;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt_q;
   logic             zero_q;

   logic [CCW-1:0]   c;
   logic             hit;   // current chunk holds a one
   logic             last;  // current chunk is the least significant one

   lzc_chunk #(.CHUNK(CHUNK)) u_chunk (
      .d(sh[WIDTH-1 -: CHUNK]),
      .c(c)
   );

   assign hit  = (c != CCW'(CHUNK));
   assign last = (idx == IW'(NCH - 1));

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)  nxt = SCAN;
         SCAN:    if (hit || last)   nxt = DONE;
         DONE:    if (bus.out_ready) nxt = IDLE;
         default:                    nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         sh     <= '0;
         acc    <= '0;
         idx    <= '0;
         cnt_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         state <= nxt;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sh  <= bus.in_data;
                  acc <= '0;
                  idx <= '0;
               end
            end
            SCAN: begin
               if (hit) begin
                  acc    <= acc + CW'(c);
                  cnt_q  <= acc + CW'(c);
                  zero_q <= 1'b0;
               end else if (last) begin
                  acc    <= acc + CW'(CHUNK);
                  cnt_q  <= acc + CW'(CHUNK);
                  zero_q <= 1'b1;
               end else begin
                  acc <= acc + CW'(CHUNK);
                  sh  <= sh << CHUNK;
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_count = cnt_q;
   assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_lzc_seq.sv
// tb_lzc_seq: self-checking bench for lzc_seq (WIDTH=32, CHUNK=8).
// Directed table, hand-written handshake/reset sequences, then random words
// checked against a bit-scan reference model.
module tb_lzc_seq;

   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int NCH   = WIDTH / CHUNK;

   typedef struct {
      logic [31:0] d;
      int          cnt;
      bit          z;
      int          lat;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   lzc_seq_if #(.WIDTH(WIDTH)) bus ();

   lzc_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // reference: leading zeros by direct bit scan
   function automatic int ref_lz(input logic [31:0] d);
      for (int i = 31; i >= 0; i--)
         if (d[i]) return 31 - i;
      return 32;
   endfunction

   // reference: SCAN cycles = chunks visited
   function automatic int ref_lat(input int cnt);
      return (cnt >= WIDTH) ? NCH : cnt / CHUNK + 1;
   endfunction

   // one transaction: accept, wait for result, hold it for hold cycles, consume
   task automatic run_word(input string tag, input logic [31:0] d, input int ecnt,
                           input bit ez, input int elat, input int hold);
      int lat;
      chk({tag, ".ready_before"}, bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.out_ready = (hold == 0);
      step();
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         step();
         lat++;
      end
      chk({tag, ".lat"}, lat, elat);
      chk({tag, ".cnt"}, bus.out_count, ecnt);
      chk({tag, ".zero"}, bus.out_zero, ez);
      chk({tag, ".no_ready"}, bus.in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         step();
         chk({tag, ".hold_v"}, bus.out_valid, 1);
         chk({tag, ".hold_c"}, bus.out_count, ecnt);
      end
      bus.out_ready = 1'b1;
      step();
      chk({tag, ".consumed"}, bus.out_valid, 0);
      chk({tag, ".ready_after"}, bus.in_ready, 1);
   endtask

   vec_t tbl[9];

   initial begin
      int n;
      logic [31:0] d;
      tbl[0] = '{32'h8000_0000,  0, 1'b0, 1};
      tbl[1] = '{32'h0001_0000, 15, 1'b0, 2};
      tbl[2] = '{32'h0000_0001, 31, 1'b0, 4};
      tbl[3] = '{32'h0000_0000, 32, 1'b1, 4};
      tbl[4] = '{32'h00F0_0000,  8, 1'b0, 2};
      tbl[5] = '{32'hFFFF_FFFF,  0, 1'b0, 1};
      tbl[6] = '{32'h0000_0100, 23, 1'b0, 3};
      tbl[7] = '{32'h0100_0000,  7, 1'b0, 1};
      tbl[8] = '{32'h0000_0080, 24, 1'b0, 4};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      reset         = 1'b1;
      step();
      step();
      // reset wins over a simultaneous in_valid
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h1234_5678;
      step();
      chk("rst.in_ready", bus.in_ready, 1);
      chk("rst.out_valid", bus.out_valid, 0);
      chk("rst.count", bus.out_count, 0);
      chk("rst.zero", bus.out_zero, 0);
      bus.in_valid = 1'b0;
      reset = 1'b0;
      step();
      chk("rst.not_accepted", bus.in_ready, 1);

      // directed table
      foreach (tbl[i])
         run_word($sformatf("tbl%0d", i), tbl[i].d, tbl[i].cnt, tbl[i].z, tbl[i].lat, 0);

      // backpressure with a pending in_valid
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h00F0_0000;
      step();
      bus.in_data = 32'h8000_0000;
      n = 0;
      while (!bus.out_valid && n < 20) begin step(); n++; end
      chk("bp.lat", n, 2);
      for (int h = 0; h < 5; h++) begin
         chk("bp.valid", bus.out_valid, 1);
         chk("bp.count", bus.out_count, 8);
         chk("bp.zero", bus.out_zero, 0);
         chk("bp.in_ready", bus.in_ready, 0);
         step();
      end
      bus.out_ready = 1'b1;
      step();
      chk("bp.consumed", bus.out_valid, 0);
      chk("bp.idle", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      step();

      // reset on the 2nd SCAN edge
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_0001;
      step();
      bus.in_valid = 1'b0;
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid.in_ready", bus.in_ready, 1);
      chk("mid.count", bus.out_count, 0);
      n = 0;
      for (int h = 0; h < 6; h++) begin
         if (bus.out_valid) n++;
         step();
      end
      chk("mid.no_valid", n, 0);

      // back-to-back with in_valid held high
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'hFFFF_FFFF;
      step();
      bus.in_data = 32'h0000_0100;
      step();
      chk("b2b.v1", bus.out_valid, 1);
      chk("b2b.c1", bus.out_count, ref_lz(32'hFFFF_FFFF));
      step();
      chk("b2b.idle", bus.in_ready, 1);
      chk("b2b.no_overlap", bus.out_valid, 0);
      step();
      chk("b2b.accept2", bus.in_ready, 0);
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 20) begin step(); n++; end
      chk("b2b.lat2", n, ref_lat(ref_lz(32'h0000_0100)));
      chk("b2b.c2", bus.out_count, ref_lz(32'h0000_0100));
      step();

      // random words against the reference model
      for (int r = 0; r < 40; r++) begin
         case ($urandom_range(0, 3))
            0:       d = 32'h0;
            1:       d = 32'h1 << $urandom_range(0, 31);
            default: d = $urandom >> $urandom_range(0, 31);
         endcase
         n = ref_lz(d);
         run_word($sformatf("rnd%0d", r), d, n, (n == WIDTH), ref_lat(n), $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
